// File: rtl/subsurf_ram_arbiter.sv
`default_nettype none
// ============================================================================
// subsurf_ram_arbiter
//   Burst-fair two-requester arbiter for one single-port 512x32 RAM.
//   Revision: 1.0
// ============================================================================
module subsurf_ram_arbiter #(
  parameter int AW        = 9,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req_i,
  input  logic [3:0]    r0_we_i,
  input  logic [AW-1:0] r0_addr_i,
  input  logic [DW-1:0] r0_wdata_i,
  output logic          r0_gnt_o,
  output logic [DW-1:0] r0_rdata_o,
  output logic          r0_rvalid_o,
  input  logic          r1_req_i,
  input  logic [3:0]    r1_we_i,
  input  logic [AW-1:0] r1_addr_i,
  input  logic [DW-1:0] r1_wdata_i,
  output logic          r1_gnt_o,
  output logic [DW-1:0] r1_rdata_o,
  output logic          r1_rvalid_o,
  output logic          ram_en_o,
  output logic [3:0]    ram_we_o,
  output logic [AW-1:0] ram_a_o,
  output logic [DW-1:0] ram_di_o,
  input  logic [DW-1:0] ram_do_i
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          rr_last_q, rr_last_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          rvalid_q, rvalid_d;
  logic          rsel_q, rsel_d;

  logic          owner;
  logic          own_req;
  logic          oth_req;
  logic          accept;
  logic [CW-1:0] cnt_inc;
  state_e        other_st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_last_q  <= 1'b1;
      beat_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      rsel_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid_q   <= rvalid_d;
      rsel_q     <= rsel_d;
    end
  end

  always_comb begin
    owner      = (state_q == ST_OWN1);
    own_req    = owner ? r1_req_i : r0_req_i;
    oth_req    = owner ? r0_req_i : r1_req_i;
    other_st   = owner ? ST_OWN0 : ST_OWN1;
    accept     = (state_q != ST_IDLE) && own_req;
    cnt_inc    = beat_cnt_q + CW'(1);

    state_d    = state_q;
    rr_last_d  = rr_last_q;
    beat_cnt_d = beat_cnt_q;
    rvalid_d   = 1'b0;
    rsel_d     = rsel_q;

    ram_en_o   = accept;
    ram_we_o   = '0;
    ram_a_o    = '0;
    ram_di_o   = '0;

    if (accept) begin
      ram_we_o = owner ? r1_we_i    : r0_we_i;
      ram_a_o  = owner ? r1_addr_i  : r0_addr_i;
      ram_di_o = owner ? r1_wdata_i : r0_wdata_i;
      if (ram_we_o == 4'b0000) begin
        rvalid_d = 1'b1;
        rsel_d   = owner;
      end
    end

    case (state_q)
      ST_IDLE: begin
        beat_cnt_d = '0;
        // On a tie the side that did not own last goes first.
        if (r0_req_i && (!r1_req_i || rr_last_q)) begin
          state_d = ST_OWN0;
        end else if (r1_req_i) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!own_req) begin
          rr_last_d  = owner;
          beat_cnt_d = '0;
          state_d    = oth_req ? other_st : ST_IDLE;
        end else if (cnt_inc == CW'(MAX_BURST)) begin
          // Burst limit reached: hand over only if the other side is waiting.
          beat_cnt_d = '0;
          if (oth_req) begin
            state_d   = other_st;
            rr_last_d = owner;
          end
        end else begin
          beat_cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  assign r0_gnt_o    = (state_q == ST_OWN0);
  assign r1_gnt_o    = (state_q == ST_OWN1);
  assign r0_rvalid_o = rvalid_q && !rsel_q;
  assign r1_rvalid_o = rvalid_q &&  rsel_q;
  assign r0_rdata_o  = rsel_q ? '0 : ram_do_i;
  assign r1_rdata_o  = rsel_q ? ram_do_i : '0;

endmodule
`default_nettype wire
